// File: rtl/fb_pixel_sink.sv
// fb_pixel_sink: receiving end of the renderer pixel stream. Clips and stores
// pixels in an on-chip framebuffer, provides a fill engine, and streams the
// framebuffer out in raster order through a register+skid output stage.
module fb_pixel_sink #(
  parameter int FB_W = 32,
  parameter int FB_H = 32,
  parameter int CW   = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    px,
  input  logic [7:0]    py,
  input  logic [CW-1:0] pixel_color,
  input  logic          pixel_valid,
  input  logic          draw_done,
  input  logic          clear_start,
  input  logic [CW-1:0] clear_color,
  input  logic          scan_start,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [7:0]    out_x,
  output logic [7:0]    out_y,
  output logic [CW-1:0] out_color,
  output logic          scan_done,
  output logic          busy,
  output logic [15:0]   prim_count,
  output logic [15:0]   clip_count
);
  localparam int DEPTH  = FB_W * FB_H;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int XW     = $clog2(FB_W);
  localparam int YW     = ADDR_W - XW;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CL_IDLE = 1'b0, CL_RUN = 1'b1} cl_state_t;
  typedef enum logic [1:0] {SC_IDLE = 2'd0, SC_RUN = 2'd1, SC_LAST = 2'd2} sc_state_t;

  cl_state_t cl_state_r, cl_state_s;
  sc_state_t sc_state_r, sc_state_s;

  logic [CW-1:0]     mem_r [DEPTH];
  logic              clearing_s, clear_go_s, in_bounds_s, accept_s, drop_s;
  logic              wr_pend_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [CW-1:0]     wr_color_r;
  logic [ADDR_W-1:0] clr_addr_r;
  logic [CW-1:0]     clr_color_r;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_wa_s;
  logic [CW-1:0]     ram_wd_s;
  logic              scan_go_s, rd_issue_s, head_pop_s, last_xfer_s;
  logic [1:0]        occ_s;
  logic [ADDR_W-1:0] rd_addr_r, rd_tag_r;
  logic [CW-1:0]     rd_data_r;
  logic              rd_inflight_r;
  logic              head_valid_r, skid_valid_r;
  logic [ADDR_W-1:0] head_addr_r, skid_addr_r;
  logic [CW-1:0]     head_color_r, skid_color_r;
  logic              scan_done_r;
  logic [15:0]       prim_r, clip_r;

  assign clearing_s  = (cl_state_r == CL_RUN);
  assign clear_go_s  = clear_start && (cl_state_r == CL_IDLE);
  assign in_bounds_s = ({1'b0, px} < 9'(FB_W)) && ({1'b0, py} < 9'(FB_H));
  // A pixel arriving in the same cycle a fill starts is dropped as well, so a
  // pending draw write can never collide with a fill write on the single port.
  assign accept_s    = pixel_valid && in_bounds_s && !clearing_s && !clear_go_s;
  assign drop_s      = pixel_valid && !accept_s;

  // Input stage: register accepted pixel coordinates and colour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend_r  <= 1'b0;
      wr_addr_r  <= {ADDR_W{1'b0}};
      wr_color_r <= {CW{1'b0}};
    end else begin
      wr_pend_r <= accept_s;
      if (accept_s) begin
        wr_addr_r  <= {py[YW-1:0], px[XW-1:0]};
        wr_color_r <= pixel_color;
      end
    end
  end

  // Fill engine next-state logic
  always_comb begin
    cl_state_s = cl_state_r;
    case (cl_state_r)
      CL_IDLE: if (clear_start) cl_state_s = CL_RUN; else cl_state_s = CL_IDLE;
      CL_RUN:  if (clr_addr_r == LAST_ADDR) cl_state_s = CL_IDLE; else cl_state_s = CL_RUN;
      default: cl_state_s = CL_IDLE;
    endcase
  end

  // Fill engine state, address counter and latched fill colour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cl_state_r  <= CL_IDLE;
      clr_addr_r  <= {ADDR_W{1'b0}};
      clr_color_r <= {CW{1'b0}};
    end else begin
      cl_state_r <= cl_state_s;
      if (clear_go_s) begin
        clr_addr_r  <= {ADDR_W{1'b0}};
        clr_color_r <= clear_color;
      end else if (clearing_s) begin
        clr_addr_r <= clr_addr_r + ADDR_W'(1);
      end
    end
  end

  // Single write port: fill has priority over the draw stage
  always_comb begin
    ram_we_s = 1'b0;
    ram_wa_s = {ADDR_W{1'b0}};
    ram_wd_s = {CW{1'b0}};
    if (clearing_s) begin
      ram_we_s = 1'b1;
      ram_wa_s = clr_addr_r;
      ram_wd_s = clr_color_r;
    end else if (wr_pend_r) begin
      ram_we_s = 1'b1;
      ram_wa_s = wr_addr_r;
      ram_wd_s = wr_color_r;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // Framebuffer storage; a read sees the contents before a same-edge write
  always_ff @(posedge clk) begin
    if (ram_we_s) mem_r[ram_wa_s] <= ram_wd_s;
    if (rd_issue_s) rd_data_r <= mem_r[rd_addr_r];
  end

  // Reads are issued only while the output stage plus the read in flight can
  // absorb the result, so the skid entry can never overflow.
  assign head_pop_s  = head_valid_r && out_ready;
  assign occ_s       = {1'b0, head_valid_r} + {1'b0, skid_valid_r} + {1'b0, rd_inflight_r};
  assign rd_issue_s  = (sc_state_r == SC_RUN) && (occ_s < (2'd2 + {1'b0, head_pop_s}));
  assign scan_go_s   = (sc_state_r == SC_IDLE) && scan_start && !clearing_s;
  assign last_xfer_s = (sc_state_r == SC_LAST) && head_pop_s && !skid_valid_r && !rd_inflight_r;

  // Scanout next-state logic
  always_comb begin
    sc_state_s = sc_state_r;
    case (sc_state_r)
      SC_IDLE: if (scan_go_s) sc_state_s = SC_RUN; else sc_state_s = SC_IDLE;
      SC_RUN:  if (rd_issue_s && (rd_addr_r == LAST_ADDR)) sc_state_s = SC_LAST; else sc_state_s = SC_RUN;
      SC_LAST: if (last_xfer_s) sc_state_s = SC_IDLE; else sc_state_s = SC_LAST;
      default: sc_state_s = SC_IDLE;
    endcase
  end

  // Scanout state, read address counter and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_state_r    <= SC_IDLE;
      rd_addr_r     <= {ADDR_W{1'b0}};
      rd_tag_r      <= {ADDR_W{1'b0}};
      rd_inflight_r <= 1'b0;
      scan_done_r   <= 1'b0;
    end else begin
      sc_state_r    <= sc_state_s;
      rd_inflight_r <= rd_issue_s;
      scan_done_r   <= last_xfer_s;
      if (scan_go_s) begin
        rd_addr_r <= {ADDR_W{1'b0}};
      end else if (rd_issue_s) begin
        rd_addr_r <= rd_addr_r + ADDR_W'(1);
        rd_tag_r  <= rd_addr_r;
      end
    end
  end

  // Output register plus skid entry; the head only changes when empty or popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid_r <= 1'b0;
      head_addr_r  <= {ADDR_W{1'b0}};
      head_color_r <= {CW{1'b0}};
      skid_valid_r <= 1'b0;
      skid_addr_r  <= {ADDR_W{1'b0}};
      skid_color_r <= {CW{1'b0}};
    end else if (!head_valid_r || head_pop_s) begin
      if (skid_valid_r) begin
        head_valid_r <= 1'b1;
        head_addr_r  <= skid_addr_r;
        head_color_r <= skid_color_r;
        skid_valid_r <= rd_inflight_r;
        skid_addr_r  <= rd_tag_r;
        skid_color_r <= rd_data_r;
      end else if (rd_inflight_r) begin
        head_valid_r <= 1'b1;
        head_addr_r  <= rd_tag_r;
        head_color_r <= rd_data_r;
      end else begin
        head_valid_r <= 1'b0;
      end
    end else if (rd_inflight_r) begin
      skid_valid_r <= 1'b1;
      skid_addr_r  <= rd_tag_r;
      skid_color_r <= rd_data_r;
    end
  end

  // Primitive counter (wrapping) and drop counter (saturating)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prim_r <= 16'd0;
      clip_r <= 16'd0;
    end else begin
      if (draw_done) prim_r <= prim_r + 16'd1;
      if (drop_s && (clip_r != 16'hFFFF)) clip_r <= clip_r + 16'd1;
    end
  end

  assign out_valid  = head_valid_r;
  assign out_x      = 8'(head_addr_r[XW-1:0]);
  assign out_y      = 8'(head_addr_r[ADDR_W-1:XW]);
  assign out_color  = head_color_r;
  assign scan_done  = scan_done_r;
  assign busy       = clearing_s || (sc_state_r != SC_IDLE);
  assign prim_count = prim_r;
  assign clip_count = clip_r;
endmodule

// File: tb/tb_fb_pixel_sink.sv
// Self-checking bench for fb_pixel_sink: randomized draws against a
// framebuffer array model, full scans compared against the model image.
module tb_fb_pixel_sink;
  localparam int W = 32;
  localparam int H = 32;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  px = 8'd0, py = 8'd0;
  logic [23:0] pixel_color = 24'd0, clear_color = 24'd0;
  logic        pixel_valid = 1'b0, draw_done = 1'b0, clear_start = 1'b0;
  logic        scan_start = 1'b0, out_ready = 1'b0;
  logic        out_valid, scan_done, busy;
  logic [7:0]  out_x, out_y;
  logic [23:0] out_color;
  logic [15:0] prim_count, clip_count;

  logic [23:0] ref_fb [N];
  int          ref_clip = 0;
  int          ref_prim = 0;
  bit          model_clearing = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  fb_pixel_sink #(.FB_W(W), .FB_H(H), .CW(24)) dut (
    .clk(clk), .rst(rst), .px(px), .py(py), .pixel_color(pixel_color),
    .pixel_valid(pixel_valid), .draw_done(draw_done), .clear_start(clear_start),
    .clear_color(clear_color), .scan_start(scan_start), .out_ready(out_ready),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_color(out_color),
    .scan_done(scan_done), .busy(busy), .prim_count(prim_count), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one pixel for one cycle (pixel_valid left high for streaming)
  task automatic send_px(input int x, input int y, input logic [23:0] c);
    px = 8'(x); py = 8'(y); pixel_color = c; pixel_valid = 1'b1;
    if (x < W && y < H && !model_clearing) ref_fb[y*W + x] = c;
    else if (ref_clip < 65535) ref_clip++;
    tick();
  endtask

  task automatic draw_rect(input int x0, input int y0, input int x1, input int y1,
                           input logic [23:0] c);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        send_px(x, y, c);
    pixel_valid = 1'b0;
    draw_done = 1'b1; tick(); draw_done = 1'b0;
    ref_prim++;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && busy; i++) tick();
    check(tag, busy, 1'b0);
  endtask

  task automatic do_clear(input logic [23:0] c);
    clear_color = c; clear_start = 1'b1; tick(); clear_start = 1'b0; clear_color = ~c;
    check("clear_busy", busy, 1'b1);
    wait_idle("clear_done");
    for (int i = 0; i < N; i++) ref_fb[i] = c;
  endtask

  // Full scan, compared against the model image in raster order
  task automatic run_scan(input bit rnd);
    logic [39:0] exp_q [$];
    logic [40:0] prev_w;
    bit stalled, xfer_prev;
    int got, dones, tail;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({8'(y), 8'(x), ref_fb[y*W + x]});
    out_ready = 1'b0;
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    check("scan_busy", busy, 1'b1);
    stalled = 1'b0; xfer_prev = 1'b0; got = 0; dones = 0; tail = -1; prev_w = 41'd0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      if (scan_done) begin
        dones++;
        check("done_after_last", {xfer_prev, got[15:0]}, {1'b1, 16'(N)});
        if (tail < 0) tail = 4;
      end
      if (stalled) check("stall_hold", {out_valid, out_y, out_x, out_color}, prev_w);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      xfer_prev = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) check("pixel", {out_y, out_x, out_color}, exp_q.pop_front());
        else check("extra_pixel", 64'(got), 64'(N - 1));
        got++;
        xfer_prev = 1'b1;
      end
      stalled = out_valid && !out_ready;
      prev_w = {out_valid, out_y, out_x, out_color};
      if (tail == 0) break;
      if (tail > 0) tail--;
      tick();
    end
    out_ready = 1'b0;
    check("scan_xfers", 64'(got), 64'(N));
    check("scan_done_pulses", 64'(dones), 64'd1);
    check("scan_idle", busy, 1'b0);
  endtask

  initial begin
    logic [23:0] cc;
    repeat (3) tick();
    // T1: reset values
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_x", out_x, 8'd0);
    check("rst_out_y", out_y, 8'd0);
    check("rst_out_color", out_color, 24'd0);
    check("rst_scan_done", scan_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_prim", prim_count, 16'd0);
    check("rst_clip", clip_count, 16'd0);
    rst = 1'b0;
    tick();

    // T2: clear to black, straight scan
    do_clear(24'h000000);
    run_scan(1'b0);

    // T3: two rectangles
    draw_rect(10, 10, 14, 12, 24'h0000FF);
    draw_rect(15, 13, 19, 15, 24'hFF0000);
    repeat (3) tick();
    check("t3_prim", prim_count, 16'(ref_prim));
    check("t3_clip", clip_count, 16'd0);
    run_scan(1'b0);

    // T4: out-of-bounds pixels are clipped
    send_px(40, 5, 24'h123456);
    send_px(3, 32, 24'h654321);
    pixel_valid = 1'b0; tick();
    check("t4_clip", clip_count, 16'd2);

    // T5: random pixels (some off-screen) and random draw_done, stalled scan
    for (int i = 0; i < 120; i++) begin
      draw_done = 1'($urandom_range(0, 3) == 0);
      if (draw_done) ref_prim++;
      send_px(int'($urandom_range(0, 39)), int'($urandom_range(0, 39)), 24'($urandom));
    end
    pixel_valid = 1'b0; draw_done = 1'b0;
    repeat (3) tick();
    check("t5_prim", prim_count, 16'(ref_prim));
    check("t5_clip", clip_count, 16'(ref_clip));
    run_scan(1'b1);

    // T6: drops during clear, ignored restarts, then reset mid-scan
    cc = 24'($urandom);
    clear_color = cc; clear_start = 1'b1; tick(); clear_start = 1'b0;
    model_clearing = 1'b1;
    repeat (5) tick();
    clear_color = ~cc; clear_start = 1'b1; tick(); clear_start = 1'b0;
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    send_px(3, 4, 24'hABCDEF);
    send_px(50, 4, 24'hABCDEF);
    pixel_valid = 1'b0; tick();
    check("t6_clip_during_clear", clip_count, 16'(ref_clip));
    wait_idle("t6_clear_done");
    model_clearing = 1'b0;
    for (int i = 0; i < N; i++) ref_fb[i] = cc;
    repeat (3) tick();
    check("t6_scan_ignored", {busy, out_valid}, 2'b00);
    send_px(7, 9, 24'h00FF00);
    pixel_valid = 1'b0; repeat (2) tick();
    run_scan(1'b1);

    scan_start = 1'b1; tick(); scan_start = 1'b0; out_ready = 1'b1;
    repeat (40) tick();
    check("midscan_valid", out_valid, 1'b1);
    rst = 1'b1; #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_clip", clip_count, 16'd0);
    ref_clip = 0; ref_prim = 0;
    tick(); rst = 1'b0; out_ready = 1'b0; tick();
    run_scan(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
